// File: rtl/zap_shifter_divide_if.sv
// zap_shifter_divide_if: divide request/result bus; master drives i_* operands and reads o_* result, slave is the divider
interface zap_shifter_divide_if #(parameter int WIDTH = 32);
  logic             i_start;
  logic             i_signed;
  logic             i_take_rem;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic [WIDTH-1:0] o_rd;
  logic             o_busy;
  logic             o_done;
  logic             o_div_by_zero;
  modport master (
    output i_start, i_signed, i_take_rem, i_dividend, i_divisor,
    input  o_rd, o_busy, o_done, o_div_by_zero
  );
  modport slave (
    input  i_start, i_signed, i_take_rem, i_dividend, i_divisor,
    output o_rd, o_busy, o_done, o_div_by_zero
  );
endinterface

// File: rtl/zap_shifter_divide.sv
// zap_shifter_divide: radix-2 restoring divider (i_clk, sync i_reset, writeback/alu flush, i_data_stall; bus carries start/operands in, rd/busy/done/div_by_zero out)
module zap_shifter_divide #(parameter int WIDTH = 32) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_clear_from_writeback,
  input  logic                i_data_stall,
  input  logic                i_clear_from_alu,
  zap_shifter_divide_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  logic [2:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_rem, r_quo;
  logic             r_sgn, r_take_rem, r_neg_q, r_neg_r, r_dbz;
  logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
  logic [WIDTH:0]   w_sh, w_trial;
  logic             w_zero;
  assign w_dvd_mag = (r_sgn && r_dvd[WIDTH-1]) ? -r_dvd : r_dvd;
  assign w_dvs_mag = (r_sgn && r_dvs[WIDTH-1]) ? -r_dvs : r_dvs;
  assign w_zero    = r_dvs == '0;
  // the bit shifted out of rem is kept so divisors with the MSB set still compare correctly
  assign w_sh      = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_sh - {1'b0, r_dvs};
  assign bus.o_busy        = (r_state == S_IDLE) ? bus.i_start : (r_state != S_DONE);
  assign bus.o_done        = r_state == S_DONE;
  assign bus.o_div_by_zero = bus.o_done && r_dbz;
  assign bus.o_rd          = !bus.o_done ? '0 : r_take_rem ? r_rem : r_quo;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_sgn      <= 1'b0;
      r_take_rem <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dbz      <= 1'b0;
    end else if (i_clear_from_writeback || (i_clear_from_alu && !i_data_stall)) begin
      r_state <= S_IDLE;
    end else if (!i_data_stall) begin
      case (r_state)
        S_IDLE: if (bus.i_start) begin
          r_dvd      <= bus.i_dividend;
          r_dvs      <= bus.i_divisor;
          r_sgn      <= bus.i_signed;
          r_take_rem <= bus.i_take_rem;
          r_state    <= S_PREP;
        end
        S_PREP: begin
          r_neg_q <= r_sgn && (r_dvd[WIDTH-1] ^ r_dvs[WIDTH-1]);
          r_neg_r <= r_sgn && r_dvd[WIDTH-1];
          r_dbz   <= w_zero;
          r_rem   <= w_zero ? r_dvd : '0;
          r_quo   <= w_zero ? '0 : w_dvd_mag;
          r_dvs   <= w_dvs_mag;
          r_cnt   <= CW'(WIDTH - 1);
          r_state <= w_zero ? S_DONE : S_ITER;
        end
        S_ITER: begin
          r_rem   <= w_trial[WIDTH] ? w_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
          r_quo   <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
          r_cnt   <= r_cnt - 1'b1;
          r_state <= (r_cnt == '0) ? S_FIX : S_ITER;
        end
        S_FIX: begin
          r_quo   <= r_neg_q ? -r_quo : r_quo;
          r_rem   <= r_neg_r ? -r_rem : r_rem;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/zap_shifter_divide.md
# zap_shifter_divide

Iterative 32/32 integer divider that reverses the shifter-stage multiplier: it takes a dividend and divisor and produces a quotient or remainder in place of the multiply FSM's product. It uses a radix-2 restoring algorithm, one quotient bit per cycle. It sits beside the multiply unit in the shifter stage and presents the same busy, stall and clear semantics to the ALU pipeline.

## Interface
- WIDTH, 32: operand and result width; iteration count equals WIDTH.
- i_clk  in  1  clock, all state updates on rising edge.
- i_reset  in  1  reset, synchronous, active-high; clock i_clk.
- i_clear_from_writeback  in  1  flush; forces IDLE regardless of stall.
- i_data_stall  in  1  freezes all state (counter, registers, FSM).
- i_clear_from_alu  in  1  flush; honoured only when i_data_stall=0.
- i_start  in  1  request a divide; sampled only in IDLE.
- i_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- i_take_rem  in  1  1 = return remainder, 0 = return quotient.
- i_dividend  in  WIDTH  numerator; captured on the accepting edge.
- i_divisor  in  WIDTH  denominator; captured on the accepting edge.
- o_rd  out  WIDTH  result; valid only while o_done=1, otherwise 0.
- o_busy  out  1  unit occupied; the pipeline must stall.
- o_done  out  1  one-cycle result strobe.
- o_div_by_zero  out  1  qualifies o_done: divisor was zero.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - o_busy=0.
  - If i_start=1, o_busy=1 combinationally in the same cycle.
  - If i_start=1 and the unit is not stalled: capture operands, i_signed and i_take_rem; go to PREP.
- PREP:
  - Form magnitudes. When signed, take |x|; |0x80000000| stays 0x80000000 as an unsigned value.
  - Record neg_q = sign(dividend) XOR sign(divisor), and neg_r = sign(dividend).
  - Clear the partial remainder.
  - If divisor==0, go to DONE. Otherwise load counter = WIDTH-1 and go to ITER.
- ITER, each cycle:
  - Shift {rem,quo} left by 1.
  - trial = rem - divisor_mag, computed at WIDTH+1 bits.
  - If trial is non-negative: rem = trial and quo[0] = 1.
  - If counter==0, go to FIX; otherwise decrement the counter.
- FIX:
  - If signed, apply negations: quo = neg_q ? -quo : quo; rem = neg_r ? -rem : rem.
  - Go to DONE.
- DONE:
  - o_done=1 and o_busy=0.
  - o_rd = i_take_rem ? rem : quo, using the captured i_take_rem.
  - Next state is IDLE. A new start is accepted only in the following IDLE cycle.
- Divide by zero: quotient = 0, remainder = dividend (ARM convention), o_div_by_zero=1 together with o_done.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0, with no flag.
- o_busy=1 in PREP, ITER and FIX.
- Outputs are combinational from registered state.

## Timing
- Reset values:
  - Outputs: o_rd=0, o_busy=0, o_done=0, o_div_by_zero=0.
  - Internal: state IDLE, counter and all datapath registers 0.
- Latency, counting the accepting IDLE cycle as cycle 0:
  - PREP is cycle 1.
  - ITER is cycles 2..WIDTH+1.
  - FIX is cycle WIDTH+2.
  - DONE is cycle WIDTH+3, which is cycle 35 for WIDTH=32.
  - Divide by zero: DONE is cycle 2.
- Stall: every stalled cycle adds one cycle of latency. In DONE under stall, o_done stays high and o_rd stays stable until the first unstalled edge.
- Priority order, highest first:
  1. i_reset
  2. i_clear_from_writeback
  3. i_clear_from_alu && !i_data_stall
  4. i_data_stall
  5. normal advance
- Clear mid-operation: state becomes IDLE on the next edge and the result is discarded, with no o_done. Operand changes after acceptance have no effect.

## Test plan
- Unsigned 100/7, i_take_rem=0 → o_done at cycle 35 with o_rd=14; repeated with i_take_rem=1 → o_rd=2; o_busy=1 in cycles 0–34.
- Signed -7/2 → quotient 0xFFFFFFFD and remainder 0xFFFFFFFF.
- Signed 7/-2 → quotient 0xFFFFFFFD and remainder 1.
- Divide by zero, 0x1234/0 → o_done at cycle 2 with o_div_by_zero=1 and quotient 0; with i_take_rem=1 → remainder 0x1234.
- Signed 0x80000000/0xFFFFFFFF → quotient 0x80000000 and remainder 0, o_div_by_zero=0.
- Unsigned 0xFFFFFFFF/1 → quotient 0xFFFFFFFF.
- i_data_stall high for 5 cycles during ITER → o_done at cycle 40 with the correct result. i_data_stall high in DONE → o_done held.
- i_clear_from_writeback at cycle 10 → IDLE next cycle, no o_done; a fresh start of 9/3 then returns 3 at its cycle 35.
- i_clear_from_alu together with i_data_stall → ignored until the stall drops.
